// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer and its prescaler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pattern_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam int DWELL_W        = 8;
  localparam int TICK_DIV_50MHZ = 5000000;  // 0.1 s per tick at 50 MHz

  // A programmed dwell of 0 behaves as 1 so the counter can never underflow.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Divides clock into a one-cycle tick every TICK_DIV enabled cycles.
// Latency: first tick TICK_DIV cycles after enable rises with the count at 0.
// Backpressure: none; clear holds the count at 0 and overrides enable.
// Ports: clock, reset (async, active-high), clear (sync), enable, tick (comb from count).
module tick_prescaler
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_50MHZ
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign tick = enable && w_last;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a NUM_STEPS-entry table of LED frames, each held for dwell*TICK_DIV clocks, wrapping.
// Latency: start sampled at edge N shows frame 0 from cycle N+1; stop returns to IDLE next cycle.
// Backpressure: none; table writes accepted every cycle in any state.
// Ports: clock, reset (async, active-high), start, stop, wr_en/wr_addr/wr_frame/wr_dwell
//        (table write), leds (registered), busy, step_idx, tick.
// Optional macro SEQ_ONESHOT_EN adds input oneshot and output done (single pass then IDLE).
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter  int TICK_DIV  = TICK_DIV_50MHZ,
  parameter  int NUM_LEDS  = 8,
  parameter  int NUM_STEPS = 4,
  localparam int SW        = $clog2(NUM_STEPS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                wr_en,
  input  logic [SW-1:0]       wr_addr,
  input  logic [NUM_LEDS-1:0] wr_frame,
  input  logic [DWELL_W-1:0]  wr_dwell,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic [SW-1:0]       step_idx,
  output logic                tick
`ifdef SEQ_ONESHOT_EN
  ,
  input  logic                oneshot,
  output logic                done
`endif
);

  seq_state_t          r_state, w_state_nxt;
  logic [SW-1:0]       r_step, w_step_nxt, w_step_inc;
  logic [NUM_LEDS-1:0] r_leds, w_leds_nxt;
  logic [DWELL_W-1:0]  r_dwell, w_dwell_nxt;
  logic [NUM_LEDS-1:0] r_frame_tab [NUM_STEPS];
  logic [DWELL_W-1:0]  r_dwell_tab [NUM_STEPS];
  logic                w_run, w_clear, w_tick, w_frame_end, w_oneshot_end;

  assign w_run   = (r_state == ST_RUN);
  // Prescaler only counts in RUN, and restarts from 0 on every entry to RUN.
  assign w_clear = (r_state == ST_IDLE) || stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .enable(w_run),
    .tick  (w_tick)
  );

  // Last tick of the current frame's dwell: the step advances on this edge.
  assign w_frame_end = w_run && !stop && w_tick && (r_dwell <= DWELL_W'(1));
  assign w_step_inc  = r_step + 1'b1;

`ifdef SEQ_ONESHOT_EN
  logic r_oneshot, r_done;

  // NUM_STEPS is a power of 2, so the last index is all ones.
  assign w_oneshot_end = r_oneshot && (&r_step);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start && !stop) begin
        r_oneshot <= oneshot;
      end
      r_done <= w_frame_end && w_oneshot_end;
    end
  end

  assign done = r_done;
`else
  assign w_oneshot_end = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_leds_nxt  = r_leds;
    w_dwell_nxt = r_dwell;
    case (r_state)
      ST_IDLE: begin
        w_leds_nxt = '0;
        w_step_nxt = '0;
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_leds_nxt  = r_frame_tab[0];
          w_dwell_nxt = dwell_eff(r_dwell_tab[0]);
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_leds_nxt  = '0;
          w_step_nxt  = '0;
        end else if (w_frame_end) begin
          if (w_oneshot_end) begin
            w_state_nxt = ST_IDLE;
            w_leds_nxt  = '0;
            w_step_nxt  = '0;
          end else begin
            // Table reads here see the pre-edge contents, so a same-edge
            // write to the entry being entered takes effect on the next pass.
            w_step_nxt  = w_step_inc;
            w_leds_nxt  = r_frame_tab[w_step_inc];
            w_dwell_nxt = dwell_eff(r_dwell_tab[w_step_inc]);
          end
        end else if (w_tick) begin
          w_dwell_nxt = r_dwell - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step  <= '0;
      r_leds  <= '0;
      r_dwell <= '0;
    end else begin
      r_step  <= w_step_nxt;
      r_leds  <= w_leds_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_frame_tab[i] <= '0;
        r_dwell_tab[i] <= DWELL_W'(1);
      end
    end else if (wr_en) begin
      r_frame_tab[wr_addr] <= wr_frame;
      r_dwell_tab[wr_addr] <= wr_dwell;
    end
  end

  assign leds     = r_leds;
  assign busy     = w_run;
  assign step_idx = r_step;
  assign tick     = w_tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: frame-level reference model compared every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pattern_sequencer;

  localparam int DIV = 4;
  localparam int NL  = 8;
  localparam int NS  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = '0;
  logic [NL-1:0] wr_frame = '0;
  logic [7:0]    wr_dwell = '0;
  logic [NL-1:0] leds;
  logic          busy;
  logic [1:0]    step_idx;
  logic          tick;
`ifdef SEQ_ONESHOT_EN
  logic          oneshot = 1'b0;
  logic          done;
`endif

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(
    .TICK_DIV (DIV),
    .NUM_LEDS (NL),
    .NUM_STEPS(NS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_frame(wr_frame),
    .wr_dwell(wr_dwell),
    .leds    (leds),
    .busy    (busy),
    .step_idx(step_idx),
    .tick    (tick)
`ifdef SEQ_ONESHOT_EN
    ,
    .oneshot (oneshot),
    .done    (done)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame / elapsed-cycle view) ----------------
  bit            m_run;
  int            m_k, m_rem, m_t;
  logic [NL-1:0] m_shown;
  bit            m_one, m_done;
  logic [NL-1:0] m_frame [NS];
  int            m_dwell [NS];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run = 0; m_k = 0; m_rem = 0; m_t = 0; m_shown = '0; m_one = 0; m_done = 0;
      for (int i = 0; i < NS; i++) begin
        m_frame[i] = '0;
        m_dwell[i] = 1;
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run   = 1;
          m_k     = 0;
          m_t     = 0;
          m_shown = m_frame[0];
          m_rem   = eff(m_dwell[0]) * DIV;
`ifdef SEQ_ONESHOT_EN
          m_one   = oneshot;
`else
          m_one   = 0;
`endif
        end
      end else if (stop) begin
        m_run = 0; m_k = 0; m_shown = '0;
      end else begin
        m_t++;
        m_rem--;
        if (m_rem == 0) begin
          if (m_one && m_k == NS - 1) begin
            m_run = 0; m_k = 0; m_shown = '0; m_done = 1;
          end else begin
            m_k     = (m_k + 1) % NS;
            m_shown = m_frame[m_k];
            m_rem   = eff(m_dwell[m_k]) * DIV;
          end
        end
      end
      if (wr_en) begin
        m_frame[wr_addr] = wr_frame;
        m_dwell[wr_addr] = int'(wr_dwell);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("model_leds", 32'(leds), 32'(m_run ? m_shown : 8'h00));
      chk("model_busy", 32'(busy), 32'(m_run));
      chk("model_step", 32'(step_idx), 32'(m_k));
      chk("model_tick", 32'(tick), 32'(m_run && (m_t % DIV == DIV - 1)));
`ifdef SEQ_ONESHOT_EN
      chk("model_done", 32'(done), 32'(m_done));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input int a, input int f, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_frame = 8'(f); wr_dwell = 8'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic wait_step(input int k, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'(step_idx) == k) begin
        ok = 1;
        break;
      end
      cyc();
    end
    chk("wait_step_timeout", 32'(ok), 32'd1);
  endtask

  function automatic int exp_leds(input int c);
    if (c <= 14) return 8'h01;
    if (c <= 22) return 8'h02;
    if (c <= 26) return 8'h04;
    if (c <= 38) return 8'h08;
    return 8'h01;
  endfunction

  task automatic load_basic();
    write_entry(0, 8'h01, 1);
    write_entry(1, 8'h02, 2);
    write_entry(2, 8'h04, 1);
    write_entry(3, 8'h08, 3);
  endtask

  initial begin
    int n;
    #12;
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_step", 32'(step_idx), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    cyc();

    // Basic playback: start sampled at edge ending "cycle 10", frame 0 from cycle 11.
    load_basic();
    cyc();
    pulse_start();
    for (int c = 11; c <= 39; c++) begin
      chk("seq_leds", 32'(leds), 32'(exp_leds(c)));
      chk("seq_tick", 32'(tick), 32'(c >= 14 && ((c - 14) % 4 == 0)));
      cyc();
    end

    // Stop during frame 2.
    wait_step(2, 40);
    chk("frame2_leds", 32'(leds), 32'h04);
    pulse_stop();
    chk("stop_leds", 32'(leds), 32'd0);
    chk("stop_step", 32'(step_idx), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_leds", 32'(leds), 32'd0);
    cyc();
    chk("startstop_busy2", 32'(busy), 32'd0);

    // Dwell 0 behaves like dwell 1.
    write_entry(2, 8'h04, 0);
    pulse_start();
    wait_step(2, 60);
    n = 0;
    while (step_idx == 2'd2 && n < 20) begin
      n++;
      cyc();
    end
    chk("dwell0_len", 32'(n), 32'd4);

    // Rewrite the displayed entry; effect only on the next pass.
    wait_step(1, 80);
    write_entry(1, 8'hFF, 2);
    chk("wr_live_leds", 32'(leds), 32'h02);
    n = 0;
    while (step_idx == 2'd1 && n < 20) begin
      chk("wr_live_hold", 32'(leds), 32'h02);
      n++;
      cyc();
    end
    wait_step(0, 80);
    wait_step(1, 80);
    chk("wr_next_pass", 32'(leds), 32'hFF);
    pulse_stop();

    // Asynchronous reset between edges while a tick is showing.
    pulse_start();
    cyc(); cyc(); cyc();
    chk("pre_reset_tick", 32'(tick), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_leds", 32'(leds), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_tick", 32'(tick), 32'd0);
    chk("areset_step", 32'(step_idx), 32'd0);
    #2;
    reset = 1'b0;
    cyc();
    // Table reads back as frame 0 / dwell 1 for every entry.
    pulse_start();
    for (int r = 0; r < 16; r++) begin
      chk("cleared_step", 32'(step_idx), 32'((r / 4) % 4));
      chk("cleared_leds", 32'(leds), 32'd0);
      chk("cleared_busy", 32'(busy), 32'd1);
      cyc();
    end
    pulse_stop();

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 20) == 0;
      stop     = ($urandom % 80) == 0;
      wr_en    = ($urandom % 6) == 0;
      wr_addr  = 2'($urandom);
      wr_frame = 8'($urandom);
      wr_dwell = 8'($urandom_range(0, 3));
`ifdef SEQ_ONESHOT_EN
      oneshot  = ($urandom % 2) == 0;
`endif
      cyc();
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    pulse_stop();

`ifdef SEQ_ONESHOT_EN
    load_basic();
    cyc();
    oneshot = 1'b1;
    pulse_start();
    oneshot = 1'b0;
    for (int c = 11; c < 39; c++) cyc();
    chk("oneshot_done", 32'(done), 32'd1);
    chk("oneshot_leds", 32'(leds), 32'd0);
    chk("oneshot_busy", 32'(busy), 32'd0);
    cyc();
    chk("oneshot_done_pulse", 32'(done), 32'd0);
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Sequencer for the board LED datapath. It owns one shared prescaler that turns clock into a slow tick, plus a small pattern table of NUM_STEPS frames. Each frame is an LED word and a dwell in ticks. On start it plays the table in order and wraps, driving the LED bus that the top level routes to LEDG, until stop is asserted.

Parameters:
TICK_DIV, 5000000, clocks per tick (0.1 s at 50 MHz); legal range is 2 or more.
NUM_LEDS, 8, width of the LED bus.
NUM_STEPS, 4, entries in the pattern table; must be a power of 2.

Ports:
clock  in  1  system clock (CLOCK_50 at top level).
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle start request; ignored unless in IDLE.
stop  in  1  single-cycle stop request; honoured in any state.
wr_en  in  1  writes the pattern table entry in this cycle.
wr_addr  in  $clog2(NUM_STEPS)  table index to write.
wr_frame  in  NUM_LEDS  LED word for that entry.
wr_dwell  in  8  dwell in ticks for that entry; 0 is treated as 1.
leds  out  NUM_LEDS  registered LED drive.
busy  out  1  high while in RUN.
step_idx  out  $clog2(NUM_STEPS)  index of the frame currently shown.
tick  out  1  one-cycle prescaler pulse; low in IDLE.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; leds=0; busy=0; step_idx=0; tick=0.
  - Prescaler and dwell counter cleared.
  - Pattern table cleared to frame=0, dwell=1.
- State machine has two states, IDLE and RUN.
- IDLE:
  - leds=0, prescaler held at 0.
  - start=1 and stop=0 at edge N gives, from cycle N+1: RUN, step_idx=0, leds=frame[0], dwell counter=dwell[0], prescaler=0.
- RUN, prescaler and tick:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick=1 exactly in the cycle where prescaler==TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after entering RUN.
- RUN, dwell and step advance:
  - On each tick the dwell counter decrements.
  - On the tick where the counter equals 1, the step advances on that edge: step_idx=(step_idx+1) mod NUM_STEPS, and leds and the dwell counter reload from the new entry.
  - Frame k is therefore visible for exactly dwell_k*TICK_DIV cycles.
  - Wrap from NUM_STEPS-1 to 0 is seamless, with no gap cycle.
- stop=1 in RUN: next cycle is IDLE with leds=0, step_idx=0, tick=0, prescaler cleared.
- start and stop in the same cycle: stop wins and the block stays in or goes to IDLE.
- start while in RUN: ignored; no restart.
- Table writes:
  - Writes are accepted in any state and take one cycle.
  - Writing the entry currently displayed does not alter leds or the running dwell count. The new value is used the next time that step is entered.
  - A write and a read of the same index on the same edge: the reload uses the old value.
- Dwell arithmetic is 8-bit unsigned and never underflows; 0 is loaded as 1.
- Asynchronous reset mid-RUN returns everything to the reset values immediately.

Optional Feature:
- Macro: SEQ_ONESHOT_EN.
- When defined:
  - Adds input oneshot (1 bit), sampled with start.
  - Adds output done (1 bit).
  - If oneshot was 1 at start, the tick that would wrap NUM_STEPS-1 to 0 instead moves to IDLE, leds=0, and pulses done for one cycle.
  - done resets to 0.
- When undefined: neither port exists and the sequence always wraps.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN);
  - the dwell width constant (8);
  - the default TICK_DIV for 50 MHz.
- One sub-module is natural: tick_prescaler.
  - Inputs: clock, reset, clear, enable.
  - Output: tick.
  - It replaces the ad-hoc count-and-compare divider and can be reused by other timed blocks.

Test Plan (TICK_DIV=4, NUM_STEPS=4):
- Load frames 0x01/0x02/0x04/0x08 with dwell 1/2/1/3, start at cycle 10 -> leds=0x01 over cycles 11-14, 0x02 over 15-22, 0x04 over 23-26, 0x08 over 27-38, 0x01 again at 39; tick every 4th cycle from cycle 14.
- start and stop asserted together in IDLE -> busy stays 0, leds stay 0; later stop during the frame-2 dwell -> next cycle leds=0, step_idx=0, tick=0.
- Entry with dwell=0 -> displayed exactly 4 cycles (same as dwell=1).
- Write step 1 with frame=0xFF while step 1 is displayed -> leds unchanged until the next pass, then shows 0xFF.
- Assert reset asynchronously mid-RUN (between edges) -> leds, busy and tick go to 0 without waiting for an edge; table reads back dwell=1 and frame=0.
- With SEQ_ONESHOT_EN and oneshot=1, same stimulus as the first test -> done pulses at cycle 39, leds=0 and busy=0 from cycle 39.
